// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Purpose : bundles the request side (control FSM) and the memory side of the
//           load/store access unit into one interface.
// Signals :
//   request  : start, we, funct3[2:0], addr[31:0], wdata[31:0]
//   status   : busy, done, misaligned, timeout, rdata[31:0]
//   memory   : mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0],
//              mem_wstrb[3:0], mem_rdata[31:0], mem_ack
// Modports:
//   slave  : the access unit itself
//   master : everything around it (control FSM plus memory)
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        start;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic        timeout;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  start, we, funct3, addr, wdata, mem_rdata, mem_ack,
    output busy, done, misaligned, timeout, rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output start, we, funct3, addr, wdata, mem_rdata, mem_ack,
    input  busy, done, misaligned, timeout, rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Purpose : executes one RISC-V style load or store per start pulse against a
//           word-wide memory with a single-cycle acknowledge. Checks the access
//           size/alignment, replicates store data across byte lanes, extracts
//           and extends load data, and aborts an access that is not
//           acknowledged within TIMEOUT_CYCLES cycles.
// Ports   :
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   bus    - mem_access_unit_if.slave (request, status and memory signals)
// Parameters:
//   TIMEOUT_CYCLES - ACCESS cycles without mem_ack before abort (1..255)
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  // Counter value on which the next non-ack cycle reaches the timeout.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [7:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_misaligned;
  logic        r_timeout;
  logic [31:0] r_rdata;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic        w_legal;
  logic        w_aligned;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata_rep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // ---- request decode (evaluated on the incoming start) --------------------
  always_comb begin
    w_legal = 1'b0;
    if (bus.we) begin
      w_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                (bus.funct3 == 3'b010);
    end else begin
      w_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                (bus.funct3 == 3'b010) || (bus.funct3 == 3'b100) ||
                (bus.funct3 == 3'b101);
    end
  end

  // funct3[1:0] encodes the size for both signed and unsigned variants.
  always_comb begin
    w_aligned = 1'b1;
    case (bus.funct3[1:0])
      2'b01:   w_aligned = (bus.addr[0] == 1'b0);
      2'b10:   w_aligned = (bus.addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  always_comb begin
    w_wstrb = 4'b1111;
    case (bus.funct3)
      3'b000:  w_wstrb = 4'b0001 << bus.addr[1:0];
      3'b001:  w_wstrb = bus.addr[1] ? 4'b1100 : 4'b0011;
      default: w_wstrb = 4'b1111;
    endcase
  end

  // Lane replication: a byte appears in all four lanes, a halfword in both
  // halves, so the memory only has to honour the strobes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
      assign w_wdata_rep[8*gi +: 8] =
        (bus.funct3 == 3'b000) ? bus.wdata[7:0] :
        (bus.funct3 == 3'b001) ? bus.wdata[8*(gi % 2) +: 8] :
                                 bus.wdata[8*gi +: 8];
    end
  endgenerate

  // ---- load formatting (uses the registered request) -----------------------
  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_lane)
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  end

  always_comb begin
    w_load_data = bus.mem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = bus.mem_rdata;
    endcase
  end

  // ---- FSM with registered outputs ------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_lane       <= 2'b00;
      r_cnt        <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
      r_rdata      <= 32'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_wstrb  <= 4'b0000;
    end else begin
      // Status flags are single-cycle pulses unless set below.
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_we        <= bus.we;
            r_funct3    <= bus.funct3;
            r_lane      <= bus.addr[1:0];
            r_mem_addr  <= {bus.addr[31:2], 2'b00};
            r_mem_wdata <= w_wdata_rep;
            r_cnt       <= 8'd0;
            r_busy      <= 1'b1;
            if (w_legal && w_aligned) begin
              r_state     <= S_ACCESS;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.we;
              r_mem_wstrb <= bus.we ? w_wstrb : 4'b0000;
            end else begin
              // Illegal size and misalignment share the misaligned flag.
              r_state      <= S_ERROR;
              r_done       <= 1'b1;
              r_misaligned <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (bus.mem_ack) begin
            if (!r_we) begin
              r_rdata <= w_load_data;
            end
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'b0000;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state     <= S_ERROR;
            r_done      <= 1'b1;
            r_timeout   <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'b0000;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE, S_ERROR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.misaligned = r_misaligned;
  assign bus.timeout    = r_timeout;
  assign bus.rdata      = r_rdata;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wstrb  = r_mem_wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Table of directed load/store vectors with hand-computed results, followed by
// hand-written sequences for timeout, start-while-busy and reset corner cases.
// The DUT is built with TIMEOUT_CYCLES = 4.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          delay;
    logic        err;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    bus.we     = v.we;
    bus.funct3 = v.f3;
    bus.addr   = v.addr;
    bus.wdata  = v.wdata;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    if (v.err) begin
      chk({tag, ".done"}, 32'(bus.done), 32'd1);
      chk({tag, ".misaligned"}, 32'(bus.misaligned), 32'd1);
      chk({tag, ".timeout"}, 32'(bus.timeout), 32'd0);
      chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'd0);
    end else begin
      chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'd1);
      chk({tag, ".done_early"}, 32'(bus.done), 32'd0);
      chk({tag, ".mem_addr"}, bus.mem_addr, v.e_maddr);
      chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(v.we));
      chk({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(v.e_wstrb));
      if (v.we) chk({tag, ".mem_wdata"}, bus.mem_wdata, v.e_mwdata);
      for (int w = 0; w <= v.delay; w++) begin
        bus.mem_ack   = (w == v.delay);
        bus.mem_rdata = v.mrd;
        @(negedge clk);
        if (w < v.delay) chk({tag, ".mem_req_held"}, 32'(bus.mem_req), 32'd1);
      end
      bus.mem_ack = 1'b0;
      chk({tag, ".done"}, 32'(bus.done), 32'd1);
      chk({tag, ".misaligned"}, 32'(bus.misaligned), 32'd0);
      chk({tag, ".mem_req_off"}, 32'(bus.mem_req), 32'd0);
      chk({tag, ".mem_wstrb_off"}, 32'(bus.mem_wstrb), 32'd0);
    end
    chk({tag, ".rdata"}, bus.rdata, v.e_rdata);
    @(negedge clk);
    chk({tag, ".done_clear"}, 32'(bus.done), 32'd0);
    chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
    $display("vec %0d we=%0b f3=%03b addr=%h -> rdata=%h", idx, v.we, v.f3, v.addr, bus.rdata);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    //            we    f3      addr          wdata         mrd          dly err maddr         mwdata        wstrb    rdata
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        1, 1'b0, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'hFFFF_FF80};
    vecs[3]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'hFFFF_FF80};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'hBEEF_0000, 3, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 32'h0000_BEEF};
    vecs[5]  = '{1'b1, 3'b000, 32'h0000_0001, 32'h1234_5677, 32'h0,        0, 1'b0, 32'h0000_0000, 32'h7777_7777, 4'b0010, 32'h0000_BEEF};
    vecs[6]  = '{1'b0, 3'b001, 32'h0000_0006, 32'h0,        32'h8001_7FFF, 0, 1'b0, 32'h0000_0004, 32'h0,        4'b0000, 32'hFFFF_8001};
    vecs[7]  = '{1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h00AB_0000, 1, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_00AB};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000_0108, 32'h0,        32'hDEAD_BEEF, 2, 1'b0, 32'h0000_0108, 32'h0,        4'b0000, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_010C, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 32'h0000_010C, 32'hCAFE_F00D, 4'b1111, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_0011, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 3'b001, 32'h0000_0203, 32'h0000_1111, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 32'h0000_007F};
    vecs[13] = '{1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h1234_8000, 0, 1'b0, 32'h0000_0000, 32'h0,        4'b0000, 32'hFFFF_8000};

    // ---- reset state; reset dominates a simultaneous start -----------------
    reset         = 1'b1;
    bus.start     = 1'b1;
    bus.we        = 1'b0;
    bus.funct3    = 3'b010;
    bus.addr      = 32'h0000_0100;
    bus.wdata     = 32'h0;
    bus.mem_rdata = 32'h0;
    bus.mem_ack   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst.mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst.rdata", bus.rdata, 32'd0);
    chk("rst.mem_addr", bus.mem_addr, 32'd0);
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("rst.still_idle", 32'(bus.busy), 32'd0);
    $display("reset checks done");

    // ---- table-driven vectors ----------------------------------------------
    for (int i = 0; i < 14; i++) begin
      run_vec(i, vecs[i]);
    end

    // ---- timeout with stray start while busy, then late ack ----------------
    bus.we     = 1'b0;
    bus.funct3 = 3'b010;
    bus.addr   = 32'h0000_0200;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("to.mem_req", 32'(bus.mem_req), 32'd1);
      chk("to.done_early", 32'(bus.done), 32'd0);
      if (c >= 2) chk("to.mem_addr_stable", bus.mem_addr, 32'h0000_0200);
      if (c == 1) begin
        bus.start  = 1'b1;
        bus.we     = 1'b1;
        bus.addr   = 32'h0000_0400;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("to.done", 32'(bus.done), 32'd1);
    chk("to.timeout", 32'(bus.timeout), 32'd1);
    chk("to.misaligned", 32'(bus.misaligned), 32'd0);
    chk("to.mem_req_off", 32'(bus.mem_req), 32'd0);
    chk("to.mem_we_off", 32'(bus.mem_we), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_5555;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("to.late_done", 32'(bus.done), 32'd0);
    chk("to.late_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("to.rdata_kept", bus.rdata, 32'hFFFF_8000);
    chk("to.mem_req_idle", 32'(bus.mem_req), 32'd0);
    $display("timeout sequence rdata=%h", bus.rdata);

    // ---- reset in the second ACCESS cycle, then a late ack -----------------
    bus.we     = 1'b0;
    bus.funct3 = 3'b010;
    bus.addr   = 32'h0000_0300;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rs.access1", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    chk("rs.access2", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    chk("rs.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rs.done", 32'(bus.done), 32'd0);
    chk("rs.busy", 32'(bus.busy), 32'd0);
    chk("rs.rdata", bus.rdata, 32'd0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("rs.done_after_ack", 32'(bus.done), 32'd0);
    chk("rs.busy_after_ack", 32'(bus.busy), 32'd0);
    chk("rs.rdata_after_ack", bus.rdata, 32'd0);
    $display("reset-in-access sequence rdata=%h", bus.rdata);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, range 1..255: ACCESS cycles without mem_ack before abort.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 start  input  1  one-cycle request from control FSM (MEMREAD/MEMWR).
REQ-006 we  input  1  1 = store, 0 = load; sampled with start.
REQ-007 funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU); sampled with start.
REQ-008 addr  input  32  byte address; sampled with start.
REQ-009 wdata  input  32  store data (rs2); sampled with start.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle completion pulse (success or error).
REQ-012 misaligned  output  1  one-cycle error flag, coincident with done.
REQ-013 timeout  output  1  one-cycle error flag, coincident with done.
REQ-014 rdata  output  32  extended load result.
REQ-015 mem_req, mem_we  output  1 each  memory request, write enable.
REQ-016 mem_addr  output  32  {addr[31:2],2'b00}.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_wstrb  output  4  byte enables, bit i = byte lane i.
REQ-019 mem_rdata  input  32;  mem_ack  input  1  memory read data and single-cycle acknowledge.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, DONE, ERROR.
REQ-021 IDLE + start: register we/funct3/addr/wdata; legal and aligned -> ACCESS, else -> ERROR.
REQ-022 Legal: loads 000/001/010/100/101; stores 000/001/010; anything else is an error flagged via misaligned.
REQ-023 Alignment: H/HU need addr[0]=0; W needs addr[1:0]=00; B/BU always aligned.
REQ-024 ACCESS: mem_req=1; mem_we, mem_addr, mem_wdata, mem_wstrb driven from registered values and stable until ack.
REQ-025 ACCESS + mem_ack: loads capture formatted mem_rdata into rdata; -> DONE.
REQ-026 ACCESS counter SHALL increment per non-ack cycle; on reaching TIMEOUT_CYCLES -> ERROR; mem_req low from next cycle.
REQ-027 DONE: done=1 one cycle -> IDLE.  ERROR: done=1 plus misaligned or timeout for one cycle -> IDLE.
REQ-028 Latency: start at edge k, ack in first ACCESS cycle -> done high in cycle k+2; error on start -> done in cycle k+1.
REQ-029 Store lanes: SB wstrb = 1<<addr[1:0], byte replicated x4; SH wstrb 0011 (addr[1]=0) or 1100, halfword replicated x2; SW 1111.
REQ-030 Load extract: lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-031 rdata SHALL hold until the next successful load; stores and errors leave it unchanged.
REQ-032 start while busy SHALL be ignored; mem_ack outside ACCESS SHALL be ignored.
REQ-033 Outside ACCESS: mem_req=0, mem_we=0, mem_wstrb=0000.

Reset
REQ-034 reset SHALL force IDLE, zero the counter, and clear busy, done, misaligned, timeout, mem_req, mem_we, mem_wstrb, rdata, mem_addr, mem_wdata on the next edge.
REQ-035 reset mid-ACCESS SHALL drop mem_req the following cycle without a done pulse; a later mem_ack is ignored.
REQ-036 reset SHALL dominate a simultaneous start or mem_ack.

Verification
REQ-037 LB addr=0x103, mem_rdata=0x80FF_1234, ack in first ACCESS cycle -> rdata=0xFFFF_FF80, done at k+2, mem_addr=0x100.
REQ-038 SH addr=0x202, wdata=0x0000_ABCD -> mem_wstrb=1100, mem_wdata=0xABCD_ABCD, mem_we=1, rdata unchanged.
REQ-039 LW addr=0x101 -> no mem_req, done+misaligned at k+1; funct3=011 load -> same.
REQ-040 LHU addr=0x002, mem_rdata=0xBEEF_0000, ack after 3 wait cycles -> rdata=0x0000_BEEF, mem_req held 4 cycles.
REQ-041 TIMEOUT_CYCLES=4, no ack -> done+timeout after 4 ACCESS cycles, mem_req low afterwards, late ack ignored.
REQ-042 reset in 2nd ACCESS cycle, then ack -> no done, busy=0, rdata=0.
